// File: rtl/residual_add.sv
// rtl/residual_add.sv - lane-wise int8 residual add of projection output and X with rounding shift and saturation
module residual_add #(
    parameter int WIDTH                = 64,
    parameter int INPUT_BASE           = 2048,
    parameter int CONNECT_OUTPUT_BASE  = 3072,
    parameter int RESIDUAL_OUTPUT_BASE = 3584,
    parameter int NUM_WORDS            = 512,
    parameter int BURST                = 8,
    parameter int RD_LAT               = 1,
    parameter int OUT_SHIFT            = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             done,
    output logic             write_en_bar0,
    output logic [WIDTH-1:0] data_in_bar0,
    output logic [31:0]      addr_bar0,
    input  logic [WIDTH-1:0] data_out_bar0,
    output logic             write_en_bar1,
    output logic [WIDTH-1:0] data_in_bar1,
    output logic [31:0]      addr_bar1,
    input  logic [WIDTH-1:0] data_out_bar1
);

    localparam int LANES = WIDTH / 8;
    localparam int KW    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int WI_W  = $clog2(NUM_WORDS + 1);
    localparam int WCW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    // Half an LSB of the shifted result; zero when no shift is applied.
    localparam int RND   = (1 << OUT_SHIFT) >> 1;

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t            state, state_n;
    logic [KW-1:0]     k, k_n;
    logic [WCW-1:0]    wcnt, wcnt_n;
    logic [WI_W-1:0]   word_idx, word_idx_n, word_idx_inc;
    logic              done_n;
    logic [RD_LAT-1:0] vld;
    logic [KW-1:0]     cap_idx;
    logic [WIDTH-1:0]  result_buf [BURST];
    logic [WIDTH-1:0]  sum_word;

    function automatic logic [7:0] lane_add(input logic [7:0] x, input logic [7:0] c);
        logic signed [10:0] s;
        s = {{3{x[7]}}, x} + {{3{c[7]}}, c} + 11'(RND);
        s = s >>> OUT_SHIFT;
        if (s > 11'sd127)
            return 8'h7F;
        else if (s < -11'sd128)
            return 8'h80;
        else
            return s[7:0];
    endfunction

    assign write_en_bar0 = 1'b0;
    assign data_in_bar0  = '0;
    assign word_idx_inc  = word_idx + WI_W'(BURST);

    always_comb begin
        state_n    = state;
        k_n        = k;
        wcnt_n     = wcnt;
        word_idx_n = word_idx;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = READ;
                    k_n        = '0;
                    word_idx_n = '0;
                end
            end
            READ: begin
                if (k == KW'(BURST - 1)) begin
                    state_n = WAIT;
                    k_n     = '0;
                    wcnt_n  = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            WAIT: begin
                if (wcnt == WCW'(RD_LAT - 1)) begin
                    state_n = WRITE;
                    k_n     = '0;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            WRITE: begin
                if (k == KW'(BURST - 1)) begin
                    k_n        = '0;
                    word_idx_n = word_idx_inc;
                    if (word_idx_inc == WI_W'(NUM_WORDS)) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = READ;
                    end
                end else begin
                    k_n = k + 1'b1;
                end
            end
            DONE: begin
                state_n    = IDLE;
                word_idx_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            k             <= '0;
            wcnt          <= '0;
            word_idx      <= '0;
            done          <= 1'b0;
            write_en_bar1 <= 1'b0;
            data_in_bar1  <= '0;
            addr_bar0     <= 32'(INPUT_BASE);
            addr_bar1     <= 32'(CONNECT_OUTPUT_BASE);
        end else begin
            state         <= state_n;
            k             <= k_n;
            wcnt          <= wcnt_n;
            word_idx      <= word_idx_n;
            done          <= done_n;
            write_en_bar1 <= (state_n == WRITE);
            data_in_bar1  <= (state_n == WRITE) ? result_buf[k_n] : '0;
            addr_bar0     <= 32'(INPUT_BASE) + 32'(word_idx_n)
                             + ((state_n == READ) ? 32'(k_n) : 32'd0);
            case (state_n)
                READ:    addr_bar1 <= 32'(CONNECT_OUTPUT_BASE) + 32'(word_idx_n) + 32'(k_n);
                WRITE:   addr_bar1 <= 32'(RESIDUAL_OUTPUT_BASE) + 32'(word_idx_n) + 32'(k_n);
                default: addr_bar1 <= 32'(CONNECT_OUTPUT_BASE) + 32'(word_idx_n);
            endcase
        end
    end

    always_comb begin
        sum_word = '0;
        for (int i = 0; i < LANES; i++)
            sum_word[8*i +: 8] = lane_add(data_out_bar0[8*i +: 8], data_out_bar1[8*i +: 8]);
    end

    // vld[RD_LAT-1] marks the cycle in which a READ-phase address has its data on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld     <= '0;
            cap_idx <= '0;
        end else begin
            vld <= RD_LAT'({vld, (state == READ)});
            if (vld[RD_LAT-1])
                cap_idx <= (cap_idx == KW'(BURST - 1)) ? '0 : cap_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld[RD_LAT-1])
            result_buf[cap_idx] <= sum_word;
    end

endmodule
